fir_coeff_loader: RTL and testbench

// Runtime coefficient writer for the bpf16 FIR: it is the load side of the coefficient store.
// - Accepts a stream of N_TAPS signed coefficients over a valid/ready interface.
// - Writes them into a shadow bank, then swaps shadow and active banks at a sample boundary

---
 rtl/fir_coeff_loader_if.sv | 13 +
 rtl/fir_coeff_loader.sv | 116 +++++++++++
 tb/tb_fir_coeff_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_loader_if.sv
// Coefficient load stream (valid/ready) for fir_coeff_loader.
// The master drives beats; the slave (the loader) returns ready.
interface fir_coeff_loader_if #(
  parameter int COEFF_WIDTH = 16
);
  logic                          s_valid;
  logic                          s_ready;
  logic signed [COEFF_WIDTH-1:0] s_data;
  logic                          s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/fir_coeff_loader.sv
// Double-banked FIR coefficient store: loads a set into the shadow bank, swaps on swap_ok.
// Define FIR_COEFF_DEFAULT_INIT_EN to reset bank 0 to the default bpf16 set instead of zeros.
module fir_coeff_loader #(
  parameter int N_TAPS      = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int ADDR_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  fir_coeff_loader_if.slave             s,
  input  logic                          swap_ok,
  input  logic [ADDR_W-1:0]             addr,
  output logic signed [COEFF_WIDTH-1:0] coeff,
  output logic                          bank_sel,
  output logic                          busy,
  output logic                          load_done,
  output logic                          load_err
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, WAIT_SWAP} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N_TAPS - 1);

`ifdef FIR_COEFF_DEFAULT_INIT_EN
  localparam int DEF_SET [16] = '{-116, -226, -179, 184, 845, 1594, 2110, 2177,
                                  1710, 790, -261, -1153, -1638, -1589, -1014, -28};
`endif

  state_t                        state, state_next;
  logic [ADDR_W-1:0]             wr_ptr, wr_ptr_next;
  logic                          beat, wr_en;
  logic                          sel_next, done_next, err_next;
  logic signed [COEFF_WIDTH-1:0] bank [2][N_TAPS];

  assign s.s_ready = (state != WAIT_SWAP);
  assign beat      = s.s_valid && s.s_ready;
  assign busy      = (state != IDLE);

  // IDLE always has wr_ptr==0, so it shares the LOAD beat handling; this also
  // covers N_TAPS==1, where the first beat is already the final one.
  always_comb begin
    state_next  = state;
    wr_ptr_next = wr_ptr;
    wr_en       = 1'b0;
    sel_next    = bank_sel;
    done_next   = 1'b0;
    err_next    = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (beat) begin
          wr_en       = 1'b1;
          wr_ptr_next = wr_ptr + 1'b1;
          if (wr_ptr == LAST_PTR) begin
            state_next = s.s_last ? WAIT_SWAP : DRAIN;
          end else if (s.s_last) begin
            err_next    = 1'b1;
            wr_ptr_next = '0;
            state_next  = IDLE;
          end else begin
            state_next = LOAD;
          end
        end
      end
      DRAIN: begin
        if (beat && s.s_last) begin
          err_next    = 1'b1;
          wr_ptr_next = '0;
          state_next  = IDLE;
        end
      end
      WAIT_SWAP: begin
        if (swap_ok) begin
          sel_next    = ~bank_sel;
          done_next   = 1'b1;
          wr_ptr_next = '0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      bank_sel  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_next;
      wr_ptr    <= wr_ptr_next;
      bank_sel  <= sel_next;
      load_done <= done_next;
      load_err  <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_TAPS; i++) begin
`ifdef FIR_COEFF_DEFAULT_INIT_EN
        bank[0][i] <= (i < 16) ? COEFF_WIDTH'(DEF_SET[i[3:0]]) : '0;
`else
        bank[0][i] <= '0;
`endif
        bank[1][i] <= '0;
      end
    end else if (wr_en) begin
      bank[~bank_sel][wr_ptr] <= s.s_data;
    end
  end

  assign coeff = (32'(addr) < 32'(N_TAPS)) ? bank[bank_sel][addr] : '0;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader: loads, swaps, aborts and reset.
module tb_fir_coeff_loader;

  typedef struct {
    logic [3:0]         addr;
    logic signed [15:0] coeff;
  } rd_vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               swap_ok;
  logic [3:0]         addr;
  logic signed [15:0] coeff;
  logic               bank_sel, busy, load_done, load_err;

  int pass_cnt = 0;
  int total    = 0;

  logic signed [15:0] model [16];
  logic signed [15:0] reset_set [16];
  rd_vec_t            rd_tab [6];

  fir_coeff_loader_if #(.COEFF_WIDTH(16)) lif ();

  fir_coeff_loader #(.N_TAPS(16), .COEFF_WIDTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .s(lif), .swap_ok(swap_ok), .addr(addr), .coeff(coeff),
    .bank_sel(bank_sel), .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [15:0] d, input logic last);
    lif.s_valid = 1'b1;
    lif.s_data  = d;
    lif.s_last  = last;
    tick();
    lif.s_valid = 1'b0;
    lif.s_last  = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input int rdy, input int sel, input int bsy,
                               input int done, input int err);
    check({tag, ".s_ready"}, int'(lif.s_ready), rdy);
    check({tag, ".bank_sel"}, int'(bank_sel), sel);
    check({tag, ".busy"}, int'(busy), bsy);
    check({tag, ".load_done"}, int'(load_done), done);
    check({tag, ".load_err"}, int'(load_err), err);
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      check($sformatf("%s.coeff[%0d]", tag, i), int'(coeff), int'(model[i]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = reset_set[i];
  endtask

  initial begin
`ifdef FIR_COEFF_DEFAULT_INIT_EN
    reset_set = '{-16'sd116, -16'sd226, -16'sd179, 16'sd184, 16'sd845, 16'sd1594, 16'sd2110,
                  16'sd2177, 16'sd1710, 16'sd790, -16'sd261, -16'sd1153, -16'sd1638,
                  -16'sd1589, -16'sd1014, -16'sd28};
`else
    for (int i = 0; i < 16; i++) reset_set[i] = '0;
`endif
    // Reads expected after loading 1..16 (tap k holds k+1).
    rd_tab[0] = '{addr: 4'd0,  coeff: 16'sd1};
    rd_tab[1] = '{addr: 4'd5,  coeff: 16'sd6};
    rd_tab[2] = '{addr: 4'd7,  coeff: 16'sd8};
    rd_tab[3] = '{addr: 4'd10, coeff: 16'sd11};
    rd_tab[4] = '{addr: 4'd14, coeff: 16'sd15};
    rd_tab[5] = '{addr: 4'd15, coeff: 16'sd16};

    lif.s_valid = 1'b0;
    lif.s_data  = '0;
    lif.s_last  = 1'b0;
    swap_ok     = 1'b0;
    addr        = '0;

    // Reset state and reset contents of the active bank.
    do_reset();
    check_outputs("reset", 1, 0, 0, 0, 0);
    check_bank("reset");

    // Full load 1..16 with swap permitted: swap two edges after the final beat.
    swap_ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      beat(16'(k + 1), k == 15);
      if (k == 0) check("load1.busy_first", int'(busy), 1);
    end
    addr = 4'd5;
    #1;
    check_outputs("load1.wait", 0, 0, 1, 0, 0);
    check("load1.coeff_before_swap", int'(coeff), int'(model[5]));
    tick();
    check_outputs("load1.swap", 1, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      addr = rd_tab[i].addr;
      #1;
      check($sformatf("load1.tab[%0d]", i), int'(coeff), int'(rd_tab[i].coeff));
    end
    tick();
    check("load1.done_pulse_end", int'(load_done), 0);
    for (int i = 0; i < 16; i++) model[i] = 16'(i + 1);

    // Load with swap held off for 20 cycles; active bank must not move.
    swap_ok = 1'b0;
    for (int k = 0; k < 16; k++) beat(16'(-3 * (k + 1)), k == 15);
    addr = 4'd5;
    begin
      int stuck = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (lif.s_ready !== 1'b0 || coeff !== 16'sd6 || bank_sel !== 1'b1 || load_done !== 1'b0)
          stuck++;
      end
      check("hold.cycles_bad", stuck, 0);
    end
    swap_ok = 1'b1;
    tick();
    check_outputs("hold.swap", 1, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) model[i] = 16'(-3 * (i + 1));
    check_bank("hold");

    // Short set: s_last on beat 9.
    for (int k = 0; k < 9; k++) beat(16'(500 + k), k == 8);
    check_outputs("short.err", 1, 0, 0, 0, 1);
    tick();
    check("short.err_pulse_end", int'(load_err), 0);
    check_bank("short");

    // Next full load after the aborted one succeeds.
    for (int k = 0; k < 16; k++) beat(16'(200 + k), k == 15);
    tick();
    check_outputs("reload.swap", 1, 1, 0, 1, 0);
    for (int i = 0; i < 16; i++) model[i] = 16'(200 + i);
    check_bank("reload");

    // Long set: 18 beats, beats 17-18 drained, error on 18.
    swap_ok = 1'b0;
    for (int k = 0; k < 18; k++) begin
      beat(16'(-1000 - k), k == 17);
      if (k == 16) check_outputs("long.drain", 1, 1, 1, 0, 0);
    end
    check_outputs("long.err", 1, 1, 0, 0, 1);
    swap_ok = 1'b1;
    tick();
    check_outputs("long.after", 1, 1, 0, 0, 0);
    check_bank("long");

    // Single beat carrying s_last in IDLE.
    beat(16'sd77, 1'b1);
    check_outputs("single.err", 1, 1, 0, 0, 1);

    // Reset in the middle of a load.
    tick();
    for (int k = 0; k < 8; k++) beat(16'(900 + k), 1'b0);
    check("midrst.busy", int'(busy), 1);
    do_reset();
    check_outputs("midrst", 1, 0, 0, 0, 0);
    check_bank("midrst");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
